// File: rtl/mc6809_dma_arbiter.sv
// Shares the 6809 bus with NREQ DMA masters: requests it via nDMABREQ, then grants round-robin bursts.
// All outputs are registered. Bursts are capped, and the CPU is guaranteed a recovery window after each release.
module mc6809_dma_arbiter #(
  parameter int NREQ        = 2,
  parameter int MAX_BURST   = 14,
  parameter int RECOVER     = 2,
  parameter int REQ_TIMEOUT = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [NREQ-1:0] req,
  input  logic            BA,
  input  logic            BS,
  output logic            nDMABREQ,
  output logic [NREQ-1:0] gnt,
  output logic            dma_own,
  output logic [7:0]      burst_cnt,
  output logic            timeout
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GRANT, S_RELEASE} state_t;

  state_t            state, state_n;
  logic [PW-1:0]     rr_ptr, rr_ptr_n, winner, winner_n, pick, off;
  logic [PW:0]       pick_sum;
  logic [2*NREQ-1:0] req_rot;
  logic [7:0]        wait_cnt, wait_cnt_n, burst_cnt_n;
  logic [3:0]        rec_cnt, rec_cnt_n;
  logic              ba_seen, ba_seen_n, ndma_n, own_n, timeout_n;
  logic [NREQ-1:0]   gnt_n;
  logic              bus_grant, any_req;

  assign bus_grant = BA & BS;
  assign any_req   = |req;

  // Rotate req so bit 0 is the master at rr_ptr; the lowest set bit is the winner's offset.
  always_comb begin
    req_rot = {req, req} >> rr_ptr;
    off     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) off = PW'(k);
    end
    pick_sum = {1'b0, rr_ptr} + {1'b0, off};
    pick     = (int'(pick_sum) >= NREQ) ? PW'(int'(pick_sum) - NREQ) : pick_sum[PW-1:0];
  end

  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    winner_n    = winner;
    wait_cnt_n  = wait_cnt;
    rec_cnt_n   = rec_cnt;
    ba_seen_n   = ba_seen;
    ndma_n      = nDMABREQ;
    gnt_n       = gnt;
    own_n       = dma_own;
    burst_cnt_n = burst_cnt;
    timeout_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          state_n    = S_REQ;
          ndma_n     = 1'b0;
          wait_cnt_n = '0;
        end
      end
      S_REQ: begin
        wait_cnt_n = wait_cnt + 8'd1;
        // A grant on the same edge as the timeout takes priority.
        if (bus_grant && any_req) begin
          state_n     = S_GRANT;
          winner_n    = pick;
          gnt_n       = '0;
          gnt_n[pick] = 1'b1;
          own_n       = 1'b1;
          burst_cnt_n = '0;
        end else if (!any_req) begin
          state_n   = S_RELEASE;
          ndma_n    = 1'b1;
          ba_seen_n = 1'b0;
          rec_cnt_n = '0;
        end else if (wait_cnt == 8'(REQ_TIMEOUT - 1)) begin
          state_n   = S_RELEASE;
          ndma_n    = 1'b1;
          timeout_n = 1'b1;
          ba_seen_n = 1'b0;
          rec_cnt_n = '0;
        end
      end
      S_GRANT: begin
        if (!req[winner] || burst_cnt == 8'(MAX_BURST - 1) || !bus_grant) begin
          state_n     = S_RELEASE;
          gnt_n       = '0;
          own_n       = 1'b0;
          ndma_n      = 1'b1;
          burst_cnt_n = '0;
          rr_ptr_n    = (int'(winner) == NREQ - 1) ? '0 : winner + PW'(1);
          ba_seen_n   = 1'b0;
          rec_cnt_n   = '0;
        end else begin
          burst_cnt_n = burst_cnt + 8'd1;
        end
      end
      S_RELEASE: begin
        // Hold off until the CPU has dropped BA, then give it RECOVER more cycles.
        if (!ba_seen) begin
          if (!BA) begin
            if (RECOVER == 0) state_n = S_IDLE;
            else ba_seen_n = 1'b1;
            rec_cnt_n = '0;
          end
        end else if (rec_cnt == 4'(RECOVER - 1)) begin
          state_n   = S_IDLE;
          ba_seen_n = 1'b0;
        end else begin
          rec_cnt_n = rec_cnt + 4'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      winner    <= '0;
      wait_cnt  <= '0;
      rec_cnt   <= '0;
      ba_seen   <= 1'b0;
      nDMABREQ  <= 1'b1;
      gnt       <= '0;
      dma_own   <= 1'b0;
      burst_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      winner    <= winner_n;
      wait_cnt  <= wait_cnt_n;
      rec_cnt   <= rec_cnt_n;
      ba_seen   <= ba_seen_n;
      nDMABREQ  <= ndma_n;
      gnt       <= gnt_n;
      dma_own   <= own_n;
      burst_cnt <= burst_cnt_n;
      timeout   <= timeout_n;
    end
  end

endmodule

// File: tb/tb_mc6809_dma_arbiter.sv
// Bench for mc6809_dma_arbiter: vector table, directed corner sequences, then random traffic vs a grant-level model.
module tb_mc6809_dma_arbiter;
  localparam int NREQ = 2, MAX_BURST = 14, RECOVER = 2, REQ_TIMEOUT = 32;

  logic            clk = 1'b0;
  logic            rst, ba, bs, ndma, own, tmo;
  logic [NREQ-1:0] req, gnt;
  logic [7:0]      bcnt;
  int              n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  mc6809_dma_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST), .RECOVER(RECOVER), .REQ_TIMEOUT(REQ_TIMEOUT)) dut (
    .CLK(clk), .RESET(rst), .req(req), .BA(ba), .BS(bs),
    .nDMABREQ(ndma), .gnt(gnt), .dma_own(own), .burst_cnt(bcnt), .timeout(tmo)
  );

  typedef struct packed {
    logic            rst;
    logic [NREQ-1:0] req;
    logic            ba;
    logic            bs;
    logic            ndma;
    logic [NREQ-1:0] gnt;
    logic            own;
    logic [7:0]      cnt;
    logic            to;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d, required %0d", name, act, exp);
  endtask

  // Drive inputs for one cycle; on return the outputs show the result of the edge that sampled them.
  task automatic step(input logic r, input logic [NREQ-1:0] q, input logic a, input logic s);
    rst = r; req = q; ba = a; bs = s;
    @(negedge clk);
  endtask

  // CPU that grants as soon as it sees the request and withdraws BA once it is released.
  task automatic run_until(input logic [NREQ-1:0] q, input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      step(1'b0, q, !ndma, !ndma);
      if (gnt != '0 && int'(bcnt) == target) ok = 1'b1;
    end
  endtask

  function automatic int rr_first(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  initial begin : main
    bit              ok, to_seen;
    int              len, bursts, rel_cyc, gap, reqcyc, tcount, gseen;
    logic [NREQ-1:0] rq, pi_req, po_gnt;
    logic            pi_ba, pi_bs, po_ndma, ba_on, bs_v, exp_to, rel, rel_pend, ba0_seen;
    int              wl, m_rr, m_win, m_len, m_reqk, ba0_cyc, w;

    //                rst req    ba  bs    ndma gnt   own cnt  to
    tbl[0]  = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 8'd0, 1'b0};
    tbl[1]  = '{1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 1'b0};
    tbl[2]  = '{1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 1'b0};
    tbl[3]  = '{1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 8'd0, 1'b0};
    tbl[4]  = '{1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 8'd1, 1'b0};
    tbl[5]  = '{1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 8'd2, 1'b0};
    tbl[6]  = '{1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 8'd3, 1'b0};
    tbl[7]  = '{1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 8'd4, 1'b0};
    tbl[8]  = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 8'd0, 1'b0};
    tbl[9]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 8'd0, 1'b0};
    tbl[10] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 8'd0, 1'b0};
    tbl[11] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 8'd0, 1'b0};
    tbl[12] = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 1'b0};
    tbl[13] = '{1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 8'd0, 1'b0};
    tbl[14] = '{1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 8'd0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].ba, tbl[i].bs);
      chk($sformatf("vec%0d_ndma", i), int'(ndma), int'(tbl[i].ndma));
      chk($sformatf("vec%0d_gnt", i), int'(gnt), int'(tbl[i].gnt));
      chk($sformatf("vec%0d_own", i), int'(own), int'(tbl[i].own));
      chk($sformatf("vec%0d_cnt", i), int'(bcnt), int'(tbl[i].cnt));
      chk($sformatf("vec%0d_timeout", i), int'(tmo), int'(tbl[i].to));
    end

    // Burst cap twice in a row; request returns BA-drop + RECOVER cycles + one idle cycle later.
    step(1'b1, '0, 1'b0, 1'b0);
    len = 0; bursts = 0; rel_cyc = -1; gap = -1;
    for (int c = 0; c < 200 && bursts < 2; c++) begin
      step(1'b0, 2'b01, !ndma, !ndma);
      if (gnt == 2'b01) len++;
      else if (len > 0) begin
        chk("cap_burst_len", len, MAX_BURST);
        bursts++; len = 0;
        if (bursts == 1) rel_cyc = c + 1;
      end
      if (bursts == 1 && gap < 0 && !ndma) gap = c + 1 - rel_cyc;
    end
    chk("cap_bursts", bursts, 2);
    chk("cap_recover_gap", gap, RECOVER + 2);

    // Timeout with the CPU never granting.
    step(1'b1, '0, 1'b0, 1'b0);
    reqcyc = 0; tcount = 0; gseen = 0; to_seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      step(1'b0, to_seen ? 2'b00 : 2'b10, 1'b0, 1'b0);
      if (gnt != '0) gseen++;
      if (tmo) begin
        tcount++;
        if (!to_seen) begin
          chk("to_req_cycles", reqcyc, REQ_TIMEOUT);
          chk("to_ndma_high", int'(ndma), 1);
        end
        to_seen = 1'b1;
      end
      if (!ndma) reqcyc++;
    end
    chk("to_pulse_count", tcount, 1);
    chk("to_no_grant", gseen, 0);

    // CPU reclaims the bus at burst_cnt 3; the next burst must go to the other master.
    step(1'b1, '0, 1'b0, 1'b0);
    run_until(2'b11, 3, ok);
    chk("reclaim_reach", int'(ok), 1);
    chk("reclaim_first_gnt", int'(gnt), 1);
    step(1'b0, 2'b11, 1'b0, 1'b1);
    chk("reclaim_gnt", int'(gnt), 0);
    chk("reclaim_own", int'(own), 0);
    chk("reclaim_ndma", int'(ndma), 1);
    run_until(2'b11, 0, ok);
    chk("reclaim_regrant", int'(ok), 1);
    chk("reclaim_rr_gnt", int'(gnt), 2);

    // Reset mid-grant, BA kept high: no release phase may follow.
    step(1'b1, '0, 1'b0, 1'b0);
    run_until(2'b01, 6, ok);
    chk("rst_reach", int'(ok), 1);
    step(1'b1, 2'b01, 1'b1, 1'b1);
    chk("rst_ndma", int'(ndma), 1);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_own", int'(own), 0);
    chk("rst_cnt", int'(bcnt), 0);
    chk("rst_timeout", int'(tmo), 0);
    step(1'b0, 2'b01, 1'b1, 1'b1);
    chk("rst_fresh_req_ndma", int'(ndma), 0);
    chk("rst_fresh_req_gnt", int'(gnt), 0);
    step(1'b0, 2'b01, 1'b1, 1'b1);
    chk("rst_fresh_gnt", int'(gnt), 1);
    chk("rst_fresh_cnt", int'(bcnt), 0);

    // Random traffic against a model of grants, burst lengths, round-robin order and recovery.
    step(1'b1, '0, 1'b0, 1'b0);
    rq = '0; ba_on = 1'b0; wl = 0; m_rr = 0; m_win = 0; m_len = 0; m_reqk = 0;
    rel_pend = 1'b0; ba0_seen = 1'b0; ba0_cyc = 0;
    po_gnt = gnt; po_ndma = ndma;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < NREQ; b++) if ($urandom_range(0, 15) == 0) rq[b] = ~rq[b];
      if (!ndma) begin
        if (!ba_on) begin
          if (wl == 0) ba_on = 1'b1;
          else wl--;
        end else if ($urandom_range(0, 39) == 0) ba_on = 1'b0;
      end else begin
        if ($urandom_range(0, 1) == 0) ba_on = 1'b0;
        wl = $urandom_range(0, 36);
      end
      bs_v = ba_on && ($urandom_range(0, 29) != 0);
      pi_req = rq; pi_ba = ba_on; pi_bs = bs_v;
      step(1'b0, rq, ba_on, bs_v);
      exp_to = 1'b0;
      if (po_gnt != '0) begin
        rel = !pi_req[m_win] || !(pi_ba && pi_bs) || (m_len == MAX_BURST);
        if (rel) begin
          chk("rnd_release_gnt", int'(gnt), 0);
          chk("rnd_release_ndma", int'(ndma), 1);
          m_rr = (m_win + 1) % NREQ; m_len = 0; rel_pend = 1'b1; ba0_seen = 1'b0;
        end else begin
          chk("rnd_hold_gnt", int'(gnt), int'(po_gnt));
          chk("rnd_hold_cnt", int'(bcnt), m_len);
          m_len++;
        end
      end else if (!po_ndma) begin
        if (pi_ba && pi_bs && pi_req != '0) begin
          w = rr_first(pi_req, m_rr);
          chk("rnd_grant_gnt", int'(gnt), 1 << w);
          chk("rnd_grant_cnt", int'(bcnt), 0);
          m_win = w; m_len = 1;
        end else if (pi_req == '0) begin
          chk("rnd_abandon_ndma", int'(ndma), 1);
          rel_pend = 1'b1; ba0_seen = 1'b0;
        end else if (m_reqk == REQ_TIMEOUT) begin
          exp_to = 1'b1;
          chk("rnd_timeout_ndma", int'(ndma), 1);
          rel_pend = 1'b1; ba0_seen = 1'b0;
        end else begin
          chk("rnd_wait_ndma", int'(ndma), 0);
          chk("rnd_wait_gnt", int'(gnt), 0);
        end
      end else begin
        if (rel_pend && !ba0_seen && !pi_ba) begin ba0_seen = 1'b1; ba0_cyc = c; end
        chk("rnd_idle_gnt", int'(gnt), 0);
        if (!ndma) begin
          chk("rnd_new_req_has_req", int'(pi_req != '0), 1);
          if (rel_pend) begin
            chk("rnd_recover_ba0", int'(ba0_seen), 1);
            chk("rnd_recover_gap", int'((c + 1 - ba0_cyc) >= RECOVER + 2), 1);
          end
          rel_pend = 1'b0;
        end
      end
      chk("rnd_timeout", int'(tmo), int'(exp_to));
      chk("rnd_invariants", int'(($countones(gnt) <= 1) && (own == (gnt != '0)) && (gnt == '0 || !ndma)), 1);
      if (!ndma && gnt == '0) m_reqk = (!po_ndma && po_gnt == '0) ? m_reqk + 1 : 1;
      po_gnt = gnt; po_ndma = ndma;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
